// File: rtl/baw_match_engine.sv
// Game-logic core for the black-and-white tile game.
// Two players each own tiles 0..N_TILES-1 and play one tile per round. The
// leader alternates every round. A round is won by the higher tile, and a
// match ends early once the trailing player can no longer catch up.
// Only tile parity (colour) is exposed before the reveal.
module baw_match_engine #(
   parameter int N_TILES = 9,
   parameter int TILE_W  = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                p1_sel_valid,
   input  logic [TILE_W-1:0]   p1_tile,
   input  logic                p2_sel_valid,
   input  logic [TILE_W-1:0]   p2_tile,
   input  logic                reveal,
   input  logic                ack,
   output logic [2:0]          state,
   output logic                leader,
   output logic                p1_color,
   output logic                p2_color,
   output logic                p1_picked,
   output logic                p2_picked,
   output logic [N_TILES-1:0]  p1_used,
   output logic [N_TILES-1:0]  p2_used,
   output logic [TILE_W-1:0]   p1_score,
   output logic [TILE_W-1:0]   p2_score,
   output logic [TILE_W-1:0]   round,
   output logic [1:0]          round_result,
   output logic                err,
   output logic                game_over,
   output logic [1:0]          winner
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_FIRST    = 3'd1;
   localparam logic [2:0] S_SECOND   = 3'd2;
   localparam logic [2:0] S_WAIT_REV = 3'd3;
   localparam logic [2:0] S_RESULT   = 3'd4;
   localparam logic [2:0] S_DONE     = 3'd5;

   localparam logic [1:0] RES_NONE = 2'b00;
   localparam logic [1:0] RES_P1   = 2'b01;
   localparam logic [1:0] RES_P2   = 2'b10;
   localparam logic [1:0] RES_DRAW = 2'b11;

   logic [2:0]         state_q, state_d;
   logic               leader_q, leader_d;
   logic [TILE_W-1:0]  p1_tile_q, p1_tile_d;
   logic [TILE_W-1:0]  p2_tile_q, p2_tile_d;
   logic               p1_color_q, p1_color_d;
   logic               p2_color_q, p2_color_d;
   logic               p1_picked_q, p1_picked_d;
   logic               p2_picked_q, p2_picked_d;
   logic [N_TILES-1:0] p1_used_q, p1_used_d;
   logic [N_TILES-1:0] p2_used_q, p2_used_d;
   logic [TILE_W-1:0]  p1_score_q, p1_score_d;
   logic [TILE_W-1:0]  p2_score_q, p2_score_d;
   logic [TILE_W-1:0]  round_q, round_d;
   logic [1:0]         round_result_q, round_result_d;
   logic               err_q, err_d;
   logic [1:0]         winner_q, winner_d;

   // The player allowed to pick right now: the leader in FIRST, the other one in SECOND.
   logic               mover_p2;
   logic               mv_valid;
   logic [TILE_W-1:0]  mv_tile;
   logic [N_TILES-1:0] mv_used;
   logic [N_TILES-1:0] mv_hit;
   logic               mv_legal;
   logic [N_TILES-1:0] p1_hit;
   logic [N_TILES-1:0] p2_hit;

   assign mover_p2 = (state_q == S_FIRST) ? leader_q : ~leader_q;
   assign mv_valid = mover_p2 ? p2_sel_valid : p1_sel_valid;
   assign mv_tile  = mover_p2 ? p2_tile      : p1_tile;
   assign mv_used  = mover_p2 ? p2_used_q    : p1_used_q;

   // One-hot tile decodes; an out-of-range tile decodes to all zeros, so it
   // can never look legal and never sets a used bit.
   genvar gi;
   generate
      for (gi = 0; gi < N_TILES; gi++) begin : g_decode
         assign mv_hit[gi] = (mv_tile   == TILE_W'(gi));
         assign p1_hit[gi] = (p1_tile_q == TILE_W'(gi));
         assign p2_hit[gi] = (p2_tile_q == TILE_W'(gi));
      end
   endgenerate

   assign mv_legal = |(mv_hit & ~mv_used);

   // Early-termination test, one bit wider so score + remaining rounds cannot wrap.
   logic [TILE_W:0] s1_x, s2_x, rem_x;
   logic            decided;

   assign s1_x    = {1'b0, p1_score_q};
   assign s2_x    = {1'b0, p2_score_q};
   assign rem_x   = (TILE_W+1)'(N_TILES) - {1'b0, round_q};
   assign decided = (round_q == TILE_W'(N_TILES)) ||
                    (s1_x > s2_x + rem_x) ||
                    (s2_x > s1_x + rem_x);

   // Next-state and datapath updates for the match FSM.
   always_comb begin
      state_d        = state_q;
      leader_d       = leader_q;
      p1_tile_d      = p1_tile_q;
      p2_tile_d      = p2_tile_q;
      p1_color_d     = p1_color_q;
      p2_color_d     = p2_color_q;
      p1_picked_d    = p1_picked_q;
      p2_picked_d    = p2_picked_q;
      p1_used_d      = p1_used_q;
      p2_used_d      = p2_used_q;
      p1_score_d     = p1_score_q;
      p2_score_d     = p2_score_q;
      round_d        = round_q;
      round_result_d = round_result_q;
      err_d          = 1'b0;
      winner_d       = winner_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               p1_score_d     = '0;
               p2_score_d     = '0;
               p1_used_d      = '0;
               p2_used_d      = '0;
               round_d        = '0;
               round_result_d = RES_NONE;
               p1_picked_d    = 1'b0;
               p2_picked_d    = 1'b0;
               p1_color_d     = 1'b0;
               p2_color_d     = 1'b0;
               leader_d       = 1'b0;
               winner_d       = 2'b00;
               state_d        = S_FIRST;
            end
         end

         S_FIRST, S_SECOND: begin
            if (mv_valid) begin
               if (mv_legal) begin
                  if (mover_p2) begin
                     p2_tile_d   = mv_tile;
                     p2_color_d  = mv_tile[0];
                     p2_picked_d = 1'b1;
                  end else begin
                     p1_tile_d   = mv_tile;
                     p1_color_d  = mv_tile[0];
                     p1_picked_d = 1'b1;
                  end
                  state_d = (state_q == S_FIRST) ? S_SECOND : S_WAIT_REV;
               end else begin
                  err_d = 1'b1;
               end
            end
         end

         S_WAIT_REV: begin
            if (reveal) begin
               if (p1_tile_q > p2_tile_q) begin
                  round_result_d = RES_P1;
                  p1_score_d     = p1_score_q + TILE_W'(1);
               end else if (p2_tile_q > p1_tile_q) begin
                  round_result_d = RES_P2;
                  p2_score_d     = p2_score_q + TILE_W'(1);
               end else begin
                  round_result_d = RES_DRAW;
               end
               p1_used_d = p1_used_q | p1_hit;
               p2_used_d = p2_used_q | p2_hit;
               round_d   = round_q + TILE_W'(1);
               state_d   = S_RESULT;
            end
         end

         S_RESULT: begin
            if (ack) begin
               p1_picked_d = 1'b0;
               p2_picked_d = 1'b0;
               leader_d    = ~leader_q;
               if (decided) begin
                  if (p1_score_q > p2_score_q)      winner_d = RES_P1;
                  else if (p2_score_q > p1_score_q) winner_d = RES_P2;
                  else                              winner_d = RES_DRAW;
                  state_d = S_DONE;
               end else begin
                  state_d = S_FIRST;
               end
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= S_IDLE;
         leader_q       <= 1'b0;
         p1_tile_q      <= '0;
         p2_tile_q      <= '0;
         p1_color_q     <= 1'b0;
         p2_color_q     <= 1'b0;
         p1_picked_q    <= 1'b0;
         p2_picked_q    <= 1'b0;
         p1_used_q      <= '0;
         p2_used_q      <= '0;
         p1_score_q     <= '0;
         p2_score_q     <= '0;
         round_q        <= '0;
         round_result_q <= RES_NONE;
         err_q          <= 1'b0;
         winner_q       <= 2'b00;
      end else begin
         state_q        <= state_d;
         leader_q       <= leader_d;
         p1_tile_q      <= p1_tile_d;
         p2_tile_q      <= p2_tile_d;
         p1_color_q     <= p1_color_d;
         p2_color_q     <= p2_color_d;
         p1_picked_q    <= p1_picked_d;
         p2_picked_q    <= p2_picked_d;
         p1_used_q      <= p1_used_d;
         p2_used_q      <= p2_used_d;
         p1_score_q     <= p1_score_d;
         p2_score_q     <= p2_score_d;
         round_q        <= round_d;
         round_result_q <= round_result_d;
         err_q          <= err_d;
         winner_q       <= winner_d;
      end
   end

   assign state        = state_q;
   assign leader       = leader_q;
   assign p1_color     = p1_color_q;
   assign p2_color     = p2_color_q;
   assign p1_picked    = p1_picked_q;
   assign p2_picked    = p2_picked_q;
   assign p1_used      = p1_used_q;
   assign p2_used      = p2_used_q;
   assign p1_score     = p1_score_q;
   assign p2_score     = p2_score_q;
   assign round        = round_q;
   assign round_result = round_result_q;
   assign err          = err_q;
   assign game_over    = (state_q == S_DONE);
   assign winner       = winner_q;

endmodule

// File: tb/tb_baw_match_engine.sv
// Self-checking bench for baw_match_engine (N_TILES=9, TILE_W=4).
// A small reference model predicts each reveal; predictions are queued when
// the reveal is driven and popped when the DUT's registered result appears.
module tb_baw_match_engine;

   localparam int N = 9;
   localparam int W = 4;

   logic          clk = 1'b0;
   logic          rst, start, reveal, ack;
   logic          p1_sel_valid, p2_sel_valid;
   logic [W-1:0]  p1_tile, p2_tile;
   logic [2:0]    state;
   logic          leader, p1_color, p2_color, p1_picked, p2_picked;
   logic [N-1:0]  p1_used, p2_used;
   logic [W-1:0]  p1_score, p2_score, round;
   logic [1:0]    round_result, winner;
   logic          err, game_over;

   always #5 clk = ~clk;

   baw_match_engine #(.N_TILES(N), .TILE_W(W)) dut (
      .clk(clk), .rst(rst), .start(start),
      .p1_sel_valid(p1_sel_valid), .p1_tile(p1_tile),
      .p2_sel_valid(p2_sel_valid), .p2_tile(p2_tile),
      .reveal(reveal), .ack(ack),
      .state(state), .leader(leader),
      .p1_color(p1_color), .p2_color(p2_color),
      .p1_picked(p1_picked), .p2_picked(p2_picked),
      .p1_used(p1_used), .p2_used(p2_used),
      .p1_score(p1_score), .p2_score(p2_score),
      .round(round), .round_result(round_result),
      .err(err), .game_over(game_over), .winner(winner)
   );

   typedef struct {
      logic [1:0]   rr;
      logic [W-1:0] s1;
      logic [W-1:0] s2;
      logic [W-1:0] rnd;
      logic [N-1:0] u1;
      logic [N-1:0] u2;
   } exp_t;

   exp_t sb[$];

   int n_cmp = 0;
   int n_bad = 0;

   // reference model
   int           m_state, m_leader, m_t1, m_t2, m_s1, m_s2, m_rnd;
   logic [N-1:0] m_u1, m_u2;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      m_state = 0; m_leader = 0; m_t1 = 0; m_t2 = 0;
      m_s1 = 0; m_s2 = 0; m_rnd = 0; m_u1 = '0; m_u2 = '0;
   endtask

   task automatic pick(input bit is_p2, input int tile, input bit legal);
      int exp_st;
      exp_st = legal ? m_state + 1 : m_state;
      if (is_p2) begin p2_sel_valid = 1'b1; p2_tile = W'(tile); end
      else       begin p1_sel_valid = 1'b1; p1_tile = W'(tile); end
      tick();
      p1_sel_valid = 1'b0;
      p2_sel_valid = 1'b0;
      $display("pick   P%0d tile=%0d -> state=%0d err=%b", is_p2 ? 2 : 1, tile, state, err);
      n_cmp++;
      if (err !== !legal) begin
         $display("FAIL pick_err: got %b want %b", err, !legal); n_bad++;
      end
      n_cmp++;
      if (state !== 3'(exp_st)) begin
         $display("FAIL pick_state: got %0d want %0d", state, exp_st); n_bad++;
      end
      if (legal) begin
         n_cmp++;
         if ((is_p2 ? {p2_picked, p2_color} : {p1_picked, p1_color}) !== {1'b1, 1'(tile % 2)}) begin
            $display("FAIL pick_color: got picked/color %b%b want 1%0d",
                     is_p2 ? p2_picked : p1_picked, is_p2 ? p2_color : p1_color, tile % 2);
            n_bad++;
         end
         if (is_p2) m_t2 = tile; else m_t1 = tile;
         m_state = exp_st;
      end else begin
         tick();
         n_cmp++;
         if (err !== 1'b0) begin
            $display("FAIL err_one_cycle: got %b want 0", err); n_bad++;
         end
      end
   endtask

   task automatic reveal_check();
      exp_t e;
      if (m_t1 > m_t2)      begin e.rr = 2'b01; m_s1++; end
      else if (m_t2 > m_t1) begin e.rr = 2'b10; m_s2++; end
      else                         e.rr = 2'b11;
      m_u1[m_t1] = 1'b1;
      m_u2[m_t2] = 1'b1;
      m_rnd++;
      e.s1 = W'(m_s1); e.s2 = W'(m_s2); e.rnd = W'(m_rnd); e.u1 = m_u1; e.u2 = m_u2;
      sb.push_back(e);
      reveal = 1'b1;
      tick();
      reveal = 1'b0;
      m_state = 4;
      e = sb.pop_front();
      $display("reveal %0d vs %0d -> rr=%b score=%0d-%0d round=%0d", m_t1, m_t2,
               round_result, p1_score, p2_score, round);
      n_cmp++;
      if ({round_result, p1_score, p2_score, round} !== {e.rr, e.s1, e.s2, e.rnd}) begin
         $display("FAIL reveal_result: got rr=%b s=%0d-%0d rnd=%0d want rr=%b s=%0d-%0d rnd=%0d",
                  round_result, p1_score, p2_score, round, e.rr, e.s1, e.s2, e.rnd);
         n_bad++;
      end
      n_cmp++;
      if ({p1_used, p2_used} !== {e.u1, e.u2}) begin
         $display("FAIL reveal_used: got %h/%h want %h/%h", p1_used, p2_used, e.u1, e.u2);
         n_bad++;
      end
      n_cmp++;
      if (state !== 3'd4) begin
         $display("FAIL reveal_state: got %0d want 4", state); n_bad++;
      end
   endtask

   task automatic ack_check();
      int rem, exp_st, exp_win;
      bit dec;
      rem = N - m_rnd;
      dec = (m_rnd == N) || (m_s1 > m_s2 + rem) || (m_s2 > m_s1 + rem);
      exp_st  = dec ? 5 : 1;
      exp_win = (m_s1 > m_s2) ? 1 : (m_s2 > m_s1) ? 2 : 3;
      m_leader = 1 - m_leader;
      ack = 1'b1;
      tick();
      ack = 1'b0;
      m_state = exp_st;
      $display("ack    -> state=%0d leader=%b game_over=%b winner=%b", state, leader, game_over, winner);
      n_cmp++;
      if ({state, leader, game_over, p1_picked, p2_picked} !==
          {3'(exp_st), 1'(m_leader), 1'(dec), 2'b00}) begin
         $display("FAIL ack_state: got st=%0d ld=%b go=%b pk=%b%b want st=%0d ld=%0d go=%0d pk=00",
                  state, leader, game_over, p1_picked, p2_picked, exp_st, m_leader, dec);
         n_bad++;
      end
      if (dec) begin
         n_cmp++;
         if (winner !== 2'(exp_win)) begin
            $display("FAIL ack_winner: got %b want %0d", winner, exp_win); n_bad++;
         end
      end
   endtask

   task automatic play_round(input int t1, input int t2);
      if (m_leader == 0) begin pick(1'b0, t1, 1'b1); pick(1'b1, t2, 1'b1); end
      else               begin pick(1'b1, t2, 1'b1); pick(1'b0, t1, 1'b1); end
      reveal_check();
      ack_check();
   endtask

   task automatic check_all_zero(input string name);
      logic [43:0] v;
      v = {state, leader, p1_color, p2_color, p1_picked, p2_picked, p1_used, p2_used,
           p1_score, p2_score, round, round_result, err, game_over, winner};
      $display("%s -> outputs=%h", name, v);
      n_cmp++;
      if (v !== '0) begin
         $display("FAIL %s: got %h want 0", name, v); n_bad++;
      end
   endtask

   task automatic do_start(input int exp_st);
      start = 1'b1;
      tick();
      start = 1'b0;
      m_state = exp_st;
      $display("start  -> state=%0d", state);
      n_cmp++;
      if ({state, leader, p1_score, p2_score, round, p1_used, p2_used} !==
          {3'(exp_st), 1'b0, W'(0), W'(0), W'(0), N'(0), N'(0)}) begin
         $display("FAIL start: got st=%0d ld=%b s=%0d-%0d rnd=%0d used=%h/%h want st=%0d, all zero",
                  state, leader, p1_score, p2_score, round, p1_used, p2_used, exp_st);
         n_bad++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      model_clear();
      check_all_zero("reset_state");
   endtask

   task automatic test_ignored_in_idle();
      reveal = 1'b1; ack = 1'b1; p1_sel_valid = 1'b1; p1_tile = W'(2);
      tick();
      reveal = 1'b0; ack = 1'b0; p1_sel_valid = 1'b0;
      check_all_zero("idle_ignores");
   endtask

   task automatic test_basic_round();
      do_start(1);
      // start, reveal and ack mean nothing while waiting for a pick
      start = 1'b1; reveal = 1'b1; ack = 1'b1;
      tick();
      start = 1'b0; reveal = 1'b0; ack = 1'b0;
      n_cmp++;
      if ({state, leader, round} !== {3'd1, 1'b0, W'(0)}) begin
         $display("FAIL first_ignores: got st=%0d ld=%b rnd=%0d want 1/0/0", state, leader, round);
         n_bad++;
      end
      pick(1'b0, 5, 1'b1);
      pick(1'b1, 3, 1'b1);
      reveal_check();
      ack_check();
   endtask

   task automatic test_ordering_and_illegal();
      // leader is P2 now; a simultaneous P1 pick must be ignored
      p1_sel_valid = 1'b1; p1_tile = W'(2);
      p2_sel_valid = 1'b1; p2_tile = W'(7);
      tick();
      p1_sel_valid = 1'b0; p2_sel_valid = 1'b0;
      $display("both   -> state=%0d picked=%b%b", state, p1_picked, p2_picked);
      n_cmp++;
      if ({state, p1_picked, p2_picked} !== {3'd2, 1'b0, 1'b1}) begin
         $display("FAIL ordering: got st=%0d pk=%b%b want st=2 pk=01", state, p1_picked, p2_picked);
         n_bad++;
      end
      m_t2 = 7; m_state = 2;
      pick(1'b0, 5, 1'b0);   // already used by P1
      pick(1'b0, 9, 1'b0);   // out of range
      pick(1'b0, 4, 1'b1);
      reveal_check();
      ack_check();
   endtask

   task automatic test_draw();
      play_round(1, 1);
   endtask

   task automatic test_draw_round();
      pick(1'b0, 6, 1'b1);
      pick(1'b1, 6, 1'b1);
      reveal_check();
   endtask

   task automatic test_reset_mid_match();
      n_cmp++;
      if (round !== W'(3)) begin
         $display("FAIL pre_reset_round: got %0d want 3", round); n_bad++;
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      model_clear();
      sb.delete();
      check_all_zero("reset_mid_match");
   endtask

   task automatic test_early_finish();
      do_start(1);
      play_round(8, 4);
      play_round(7, 3);
      play_round(6, 2);
      play_round(5, 1);
      play_round(4, 0);
      n_cmp++;
      if ({state, game_over, winner, round} !== {3'd5, 1'b1, 2'b01, W'(5)}) begin
         $display("FAIL early_finish: got st=%0d go=%b win=%b rnd=%0d want 5/1/01/5",
                  state, game_over, winner, round);
         n_bad++;
      end
      do_start(1);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; reveal = 1'b0; ack = 1'b0;
      p1_sel_valid = 1'b0; p2_sel_valid = 1'b0; p1_tile = '0; p2_tile = '0;
      model_clear();
      test_reset();
      test_ignored_in_idle();
      test_basic_round();
      test_ordering_and_illegal();
      test_draw_round();
      test_reset_mid_match();
      test_early_finish();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
